flash_read_responder: RTL and testbench
=======================================

Name: flash_read_responder

Overview:
- Responder side of the player's flash-read handshake.
- Accepts a read request and 23-bit word address from the playback FSM, then runs one Avalon-MM read on the flash controller port.
- Latches the 32-bit word, pulses done_signal, and holds the data stable for the player to select its audio byte.
- Sits between the playback FSM and the flash controller IP, in the clk50M domain.

Parameters:
ADDR_W, 23, word address width
DATA_W, 32, flash read data width
TIMEOUT_CYCLES, 1024, clk50M cycles allowed from request issue to readdatavalid (used only with FLASH_READ_TIMEOUT_EN)

Ports:
clk50M  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
start  in  1  read request from the player; level, held until done_signal is seen
address  in  ADDR_W  word address, sampled when the request is accepted
done_signal  out  1  one-cycle pulse; readdata is valid in this cycle and afterwards
readdata  out  DATA_W  latched flash word; holds until the next completion
busy  out  1  high from acceptance until the block returns to IDLE
error  out  1  timeout flag (see Optional Feature)
flash_mem_read  out  1  Avalon read strobe
flash_mem_address  out  ADDR_W  Avalon address
flash_mem_byteenable  out  4  constant 4'b1111
flash_mem_burstcount  out  6  constant 6'd1
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdatavalid  in  1  Avalon read data valid
flash_mem_readdata  in  DATA_W  Avalon read data

Behaviour:
- Reset values: done_signal=0, readdata=0, busy=0, error=0, flash_mem_read=0, flash_mem_address=0, state=IDLE. All outputs are registered.

States: IDLE, ISSUE, WAIT_VALID, DONE, RELEASE.
- IDLE: if start=1, latch address into flash_mem_address, set flash_mem_read=1 and busy=1, go to ISSUE.
- ISSUE: hold flash_mem_read=1 and the address stable while flash_mem_waitrequest=1. On the first cycle with waitrequest=0, the command is accepted: flash_mem_read=0 next cycle, go to WAIT_VALID.
- ISSUE, simultaneous events: if readdatavalid=1 in the same cycle that waitrequest=0, latch the data and go directly to DONE.
- WAIT_VALID: on readdatavalid=1, readdata<=flash_mem_readdata and go to DONE.
- DONE: done_signal=1 for exactly one cycle, then go to RELEASE.
- RELEASE: stay until start=0, then busy=0 and go to IDLE. This prevents a second read from the initiator's registered request, which stays high for one or more cycles after done.

Latency:
- Minimum is start in cycle 0, read strobe in cycle 1, data in cycle 2, done_signal in cycle 3 (waitrequest=0 in cycle 1, readdatavalid in cycle 2).

Boundary conditions:
- readdatavalid in IDLE or RELEASE, including after a reset mid-transfer, is ignored; readdata is unchanged.
- Address changes after acceptance have no effect on the transfer in progress.
- Address 0x7FFFFF and 0x000000 pass unmodified; the block performs no wrap or arithmetic.
- Reset in any state returns to IDLE next cycle with flash_mem_read=0 and done_signal=0.
- Only one outstanding read at a time.

Optional Feature:
Macro FLASH_READ_TIMEOUT_EN.
- Defined:
  - A counter clears on acceptance in IDLE and increments each cycle in ISSUE/WAIT_VALID.
  - When the counter reaches TIMEOUT_CYCLES-1, flash_mem_read drops, readdata<=0, error<=1, and the FSM goes to DONE (done_signal still pulses).
  - error stays sticky until the next request is accepted in IDLE.
- Undefined: error is tied 0, there is no counter, and the FSM waits indefinitely.

Test Plan:
- Zero-wait read: start=1, address=0x000010, waitrequest=0, readdatavalid one cycle after the strobe with data 0xA1B2C3D4 -> a single strobe with address 0x000010, done_signal high in cycle 3, readdata=0xA1B2C3D4 held.
- Stall: waitrequest=1 for 5 cycles -> flash_mem_read and address stay constant for 6 cycles, exactly one accepted command, done after readdatavalid.
- Held request: start held 3 cycles past done_signal -> no second strobe, busy falls the cycle after start=0, next start gives a new read.
- Reset mid-WAIT_VALID, then readdatavalid=1 with 0xFFFFFFFF -> no done_signal, readdata=0, flash_mem_read=0.
- Address 0x7FFFFF, then 0x000000 back-to-back -> both presented unmodified, each with one done pulse.
- FLASH_READ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and readdatavalid never asserted -> done_signal at cycle 17 after acceptance, error=1, readdata=0; error clears on the next accepted start.

Source files
------------

// File: rtl/flash_read_responder_if.sv
// Player flash-read handshake plus Avalon-MM read port of the flash controller.
// slave: the responder's view; master: the player and flash-controller side.
interface flash_read_responder_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] address;
    logic              done_signal;
    logic [DATA_W-1:0] readdata;
    logic              busy;
    logic              error;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic [5:0]        flash_mem_burstcount;
    logic              flash_mem_waitrequest;
    logic              flash_mem_readdatavalid;
    logic [DATA_W-1:0] flash_mem_readdata;

    modport slave (
        input  start, address,
        input  flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
        output done_signal, readdata, busy, error,
        output flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount
    );

    modport master (
        output start, address,
        output flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
        input  done_signal, readdata, busy, error,
        input  flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount
    );
endinterface

// File: rtl/flash_read_responder.sv
// Runs one Avalon-MM flash read per player request and holds the returned word.
// Optional read timeout with a sticky error flag: define FLASH_READ_TIMEOUT_EN.
module flash_read_responder #(
    parameter int unsigned ADDR_W         = 23,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk50M,
    input  logic                    reset,
    flash_read_responder_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_VALID,
        S_DONE,
        S_RELEASE
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t            r_state;
    logic              r_done;
    logic              r_busy;
    logic              r_error;
    logic              r_read;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_data_ok;

    // Data is taken in WAIT_VALID, or in ISSUE when it arrives with command acceptance.
    assign w_data_ok = bus.flash_mem_readdatavalid &&
                       ((r_state == S_WAIT_VALID) || !bus.flash_mem_waitrequest);

`ifdef FLASH_READ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;
    assign w_timeout = (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge clk50M) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
            r_read  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
`ifdef FLASH_READ_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr  <= bus.address;
                        r_read  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
`ifdef FLASH_READ_TIMEOUT_EN
                        r_cnt   <= '0;
                        r_error <= 1'b0;
`endif
                    end
                end
                S_ISSUE, S_WAIT_VALID: begin
`ifdef FLASH_READ_TIMEOUT_EN
                    r_cnt <= r_cnt + CNT_W'(1);
`endif
                    if (w_data_ok) begin
                        r_read  <= 1'b0;
                        r_data  <= bus.flash_mem_readdata;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
`ifdef FLASH_READ_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_read  <= 1'b0;
                        r_data  <= '0;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
`endif
                    else if ((r_state == S_ISSUE) && !bus.flash_mem_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= S_WAIT_VALID;
                    end
                end
                S_DONE: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Wait out the player's registered request before re-arming.
                    if (!bus.start) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_read  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.done_signal          = r_done;
    assign bus.readdata             = r_data;
    assign bus.busy                 = r_busy;
    assign bus.error                = r_error;
    assign bus.flash_mem_read       = r_read;
    assign bus.flash_mem_address    = r_addr;
    assign bus.flash_mem_byteenable = 4'b1111;
    assign bus.flash_mem_burstcount = 6'd1;

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed and randomized reads of flash_read_responder against a cycle-timeline model.
// Exercises the timeout path too when FLASH_READ_TIMEOUT_EN is defined.
module tb_flash_read_responder;

    localparam int unsigned ADDR_W         = 23;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic clk50M = 1'b0;
    logic reset;

    flash_read_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    flash_read_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk50M(clk50M),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk50M = ~clk50M;

    int n_checks = 0;
    int n_pass = 0;
    int n_accepts = 0;
    logic [DATA_W-1:0] prev_data;

    // Count Avalon commands accepted by the slave.
    always @(posedge clk50M)
        if (!reset && bus.flash_mem_read && !bus.flash_mem_waitrequest) n_accepts++;

    task automatic step();
        @(posedge clk50M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Cycle 0 presents start; strobe is seen in cycles 1..1+w, the command is accepted
    // in cycle 1+w, data arrives l cycles later and done follows one cycle after that.
    task automatic run_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int w, input int l, input int hold);
        int acc_c, rdv_c, done_c, drop_c, acc0;
        acc_c  = 1 + w;
        rdv_c  = acc_c + l;
        done_c = rdv_c + 1;
        drop_c = done_c + hold + 1;
        acc0   = n_accepts;
        for (int cyc = 0; cyc <= drop_c + 1; cyc++) begin
            int n;
            n = cyc + 1;
            bus.start                   = (cyc < drop_c);
            bus.address                 = (cyc == 0) ? a : ADDR_W'($urandom);
            bus.flash_mem_waitrequest   = (cyc < acc_c);
            bus.flash_mem_readdatavalid = (cyc == rdv_c) || (cyc > done_c && $urandom_range(1, 0) == 1);
            bus.flash_mem_readdata      = (cyc == rdv_c) ? d : DATA_W'($urandom);
            step();
            chk("read", 64'(bus.flash_mem_read), 64'(n >= 1 && n <= acc_c));
            if (bus.flash_mem_read) chk("addr", 64'(bus.flash_mem_address), 64'(a));
            chk("done", 64'(bus.done_signal), 64'(n == done_c));
            chk("busy", 64'(bus.busy), 64'(n <= drop_c));
            chk("error", 64'(bus.error), 64'd0);
            chk("rdata", 64'(bus.readdata), 64'((n >= done_c) ? d : prev_data));
        end
        prev_data = d;
        chk("one_cmd", 64'(n_accepts - acc0), 64'd1);
        bus.start                   = 1'b0;
        bus.flash_mem_readdatavalid = 1'b0;
    endtask

    initial begin
        reset                       = 1'b1;
        bus.start                   = 1'b0;
        bus.address                 = '0;
        bus.flash_mem_waitrequest   = 1'b0;
        bus.flash_mem_readdatavalid = 1'b0;
        bus.flash_mem_readdata      = '0;
        prev_data                   = '0;
        step();
        step();
        chk("rst_done", 64'(bus.done_signal), 64'd0);
        chk("rst_rdata", 64'(bus.readdata), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_read", 64'(bus.flash_mem_read), 64'd0);
        chk("rst_addr", 64'(bus.flash_mem_address), 64'd0);
        chk("byteen", 64'(bus.flash_mem_byteenable), 64'hF);
        chk("burst", 64'(bus.flash_mem_burstcount), 64'd1);
        reset = 1'b0;
        step();
        chk("idle_read", 64'(bus.flash_mem_read), 64'd0);

        // Directed: zero-wait, stall, held request, simultaneous accept+data, address extremes.
        run_read(23'h000010, 32'hA1B2C3D4, 0, 1, 0);
        run_read(23'h0ABCDE, 32'h0BADF00D, 5, 2, 0);
        run_read(23'h000100, 32'h13572468, 0, 1, 3);
        run_read(23'h000101, 32'h24681357, 2, 0, 0);
        run_read(23'h7FFFFF, 32'hDEADBEEF, 0, 1, 0);
        run_read(23'h000000, 32'h00C0FFEE, 0, 1, 0);

        // Reset while the strobe is stalled.
        bus.start = 1'b1;
        bus.address = 23'h00ABCD;
        bus.flash_mem_waitrequest = 1'b1;
        step();
        step();
        chk("stall_read", 64'(bus.flash_mem_read), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.flash_mem_waitrequest = 1'b0;
        chk("rst_issue_read", 64'(bus.flash_mem_read), 64'd0);
        chk("rst_issue_busy", 64'(bus.busy), 64'd0);
        chk("rst_issue_rdata", 64'(bus.readdata), 64'd0);
        prev_data = '0;
        step();

        // Reset in WAIT_VALID, then a stray readdatavalid.
        run_read(23'h000321, 32'h11223344, 0, 1, 0);
        bus.start = 1'b1;
        bus.address = 23'h123456;
        bus.flash_mem_waitrequest = 1'b0;
        step();
        step();
        chk("wv_read", 64'(bus.flash_mem_read), 64'd0);
        chk("wv_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        chk("rst_wv_read", 64'(bus.flash_mem_read), 64'd0);
        chk("rst_wv_done", 64'(bus.done_signal), 64'd0);
        chk("rst_wv_rdata", 64'(bus.readdata), 64'd0);
        bus.flash_mem_readdatavalid = 1'b1;
        bus.flash_mem_readdata = 32'hFFFFFFFF;
        step();
        bus.flash_mem_readdatavalid = 1'b0;
        chk("stray_rdata", 64'(bus.readdata), 64'd0);
        chk("stray_done", 64'(bus.done_signal), 64'd0);
        chk("stray_read", 64'(bus.flash_mem_read), 64'd0);
        step();
        chk("stray_done2", 64'(bus.done_signal), 64'd0);
        prev_data = '0;

`ifdef FLASH_READ_TIMEOUT_EN
        // No readdatavalid: done at cycle TIMEOUT_CYCLES+1 after acceptance, error sticky.
        for (int cyc = 0; cyc <= 20; cyc++) begin
            int n;
            n = cyc + 1;
            bus.start = (cyc <= int'(TIMEOUT_CYCLES) + 1);
            bus.address = (cyc == 0) ? 23'h000055 : ADDR_W'($urandom);
            bus.flash_mem_waitrequest = (cyc < 1);
            bus.flash_mem_readdatavalid = 1'b0;
            bus.flash_mem_readdata = DATA_W'($urandom);
            step();
            chk("to_done", 64'(bus.done_signal), 64'(n == int'(TIMEOUT_CYCLES) + 1));
            chk("to_error", 64'(bus.error), 64'(n >= int'(TIMEOUT_CYCLES) + 1));
            chk("to_rdata", 64'(bus.readdata), 64'((n >= int'(TIMEOUT_CYCLES) + 1) ? '0 : prev_data));
            chk("to_busy", 64'(bus.busy), 64'(n <= int'(TIMEOUT_CYCLES) + 2));
        end
        bus.start = 1'b0;
        prev_data = '0;
        run_read(23'h000077, 32'h5A5A5A5A, 0, 1, 0);
`endif

        // Randomized reads.
        for (int i = 0; i < 10; i++)
            run_read(ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(4, 0),
                     $urandom_range(4, 0), $urandom_range(3, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
